// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Intrusion alarm controller: DISARMED -> EXIT (leave delay) -> ARMED ->
//   ENTRY (grace delay) -> ALARM (siren) -> ARMED. One 8-bit down-counter
//   times every delayed state. Sensors are asynchronous and pass through
//   2-flop synchronizers before forming the trigger.
//
//   Parameters: EXIT_CYC, ENTRY_CYC, SIREN_CYC (1..256) dwell cycles.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     arm        arm request (level)
//     disarm     disarm request (level, highest priority after rst)
//     motion     asynchronous motion sensor
//     door       asynchronous door sensor
//     window     asynchronous window sensor
//     state      current state code (0..4)
//     siren      high while in ALARM
//     armed_led  high in every state except DISARMED
//     evt_cnt    saturating count of ENTRY->ALARM transitions
//   Build option: define ALARM_EVT_COUNT_EN to include the event counter;
//   without it evt_cnt is tied to zero.
module alarm_sequencer #(
  parameter int unsigned EXIT_CYC  = 16,
  parameter int unsigned ENTRY_CYC = 8,
  parameter int unsigned SIREN_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       disarm,
  input  logic       motion,
  input  logic       door,
  input  logic       window,
  output logic [2:0] state,
  output logic       siren,
  output logic       armed_led,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [7:0] EXIT_LD  = 8'(EXIT_CYC - 1);
  localparam logic [7:0] ENTRY_LD = 8'(ENTRY_CYC - 1);
  localparam logic [7:0] SIREN_LD = 8'(SIREN_CYC - 1);

  state_t     r_state;
  logic [7:0] r_tmr;
  logic       r_siren;
  logic       r_armed_led;
  // Synchronizer stages, bit order {motion, door, window}
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  state_t     w_next;
  logic [7:0] w_tmr_next;
  logic       w_trig;

  assign w_trig = (r_sync2[2] & r_sync2[1]) | r_sync2[0];

  always_comb begin
    w_next     = r_state;
    w_tmr_next = r_tmr;
    if (disarm) begin
      w_next     = S_DISARMED;
      w_tmr_next = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (arm) begin
            w_next     = S_EXIT;
            w_tmr_next = EXIT_LD;
          end
        end
        S_EXIT: begin
          if (r_tmr == '0) w_next = S_ARMED;
          else             w_tmr_next = r_tmr - 8'd1;
        end
        S_ARMED: begin
          if (w_trig) begin
            w_next     = S_ENTRY;
            w_tmr_next = ENTRY_LD;
          end
        end
        S_ENTRY: begin
          if (r_tmr == '0) begin
            w_next     = S_ALARM;
            w_tmr_next = SIREN_LD;
          end else begin
            w_tmr_next = r_tmr - 8'd1;
          end
        end
        S_ALARM: begin
          if (r_tmr == '0) w_next = S_ARMED;
          else             w_tmr_next = r_tmr - 8'd1;
        end
        default: begin
          w_next     = S_DISARMED;
          w_tmr_next = '0;
        end
      endcase
    end
  end

  // siren/armed_led are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_DISARMED;
      r_tmr       <= '0;
      r_siren     <= 1'b0;
      r_armed_led <= 1'b0;
      r_sync1     <= '0;
      r_sync2     <= '0;
    end else begin
      r_state     <= w_next;
      r_tmr       <= w_tmr_next;
      r_siren     <= (w_next == S_ALARM);
      r_armed_led <= (w_next != S_DISARMED);
      r_sync1     <= {motion, door, window};
      r_sync2     <= r_sync1;
    end
  end

  assign state     = r_state;
  assign siren     = r_siren;
  assign armed_led = r_armed_led;

`ifdef ALARM_EVT_COUNT_EN
  logic [7:0] r_evt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_cnt <= '0;
    end else if ((r_state == S_ENTRY) && (w_next == S_ALARM) && (r_evt_cnt != '1)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = '0;
`endif

endmodule
